// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   HEX7_TABLE : nibble -> active-high segments {g,f,e,d,c,b,a}
//   SEG_*      : bit positions inside the 8-bit segment bus
//   mode_e     : display mode encoding
package seg_pkg;

  // Segment bit positions, bus order {dp,g,f,e,d,c,b,a}.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  typedef enum logic {
    MODE_HEX   = 1'b0,
    MODE_GRAPH = 1'b1
  } mode_e;

  // Standard 0-F glyphs, 1 = lit, index = nibble value.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex digit decoder.
//   nibble_i : 4-bit value to show
//   seg_o    : active-high segments {g,f,e,d,c,b,a}
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX7_TABLE[nibble_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display scanner with double-buffered content.
// A load lands in a pending set and is promoted to the active set only at a
// frame wrap, so a frame is never drawn with mixed old/new content.
//   clk, rst    : clock, synchronous active-high reset
//   load        : strobe capturing mode, disp_data, dp, blink_en
//   mode        : 0 = hex nibbles, 1 = raw segment bytes
//   disp_data   : per-digit byte (graphic) or nibble (hex)
//   dp          : per-digit decimal point (hex mode only)
//   blink_en    : per-digit blink enable
//   an          : active-low digit enables
//   seg         : active-low segments {dp,g,f,e,d,c,b,a}
//   busy        : a captured load is waiting for the next wrap
//   frame_tick  : one-cycle pulse after each scan wrap
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  mode,
  input  logic [DIGITS*8-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  busy,
  output logic                  frame_tick
);

  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned FcW  = BLINK_LOG2;

  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_ctrl: DIGITS must be 2..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("seg_scan_ctrl: SCAN_DIV must be >= 2");
  end
  if (BLINK_LOG2 < 1 || BLINK_LOG2 > 8) begin : g_bad_blink
    $error("seg_scan_ctrl: BLINK_LOG2 must be 1..8");
  end

  // Scan timing state
  logic [DivW-1:0]       div_q;
  logic [IdxW-1:0]       idx_q;
  logic [FcW-1:0]        fcnt_q;
  logic                  phase_q;

  // Pending register set
  mode_e                 pend_mode_q;
  logic [DIGITS*8-1:0]   pend_data_q;
  logic [DIGITS-1:0]     pend_dp_q;
  logic [DIGITS-1:0]     pend_blink_q;
  logic                  busy_q;

  // Active register set, the only source for the display
  mode_e                 act_mode_q;
  logic [DIGITS*8-1:0]   act_data_q;
  logic [DIGITS-1:0]     act_dp_q;
  logic [DIGITS-1:0]     act_blink_q;

  // Registered outputs
  logic [DIGITS-1:0]     an_q;
  logic [7:0]            seg_q;
  logic                  frame_tick_q;

  logic                  step;
  logic                  wrap;
  logic [3:0]            cur_nibble;
  logic [7:0]            cur_byte;
  logic [6:0]            hex_seg;
  logic [7:0]            lit;
  logic [DIGITS-1:0]     an_d;
  logic [7:0]            seg_d;

  assign step = (div_q == DivW'(SCAN_DIV - 1));
  assign wrap = step && (idx_q == IdxW'(DIGITS - 1));

  hex7seg_dec u_hex7seg_dec (
    .nibble_i (cur_nibble),
    .seg_o    (hex_seg)
  );

  // Output decode for the digit currently indexed; registered below.
  always_comb begin
    cur_nibble = act_data_q[int'(idx_q) * 4 +: 4];
    cur_byte   = act_data_q[int'(idx_q) * 8 +: 8];
    an_d       = ~(DIGITS'(1) << idx_q);
    lit        = '0;
    if (act_mode_q == MODE_GRAPH) begin
      lit = cur_byte;
    end else begin
      lit[SEG_DP]     = act_dp_q[idx_q];
      lit[SEG_G:SEG_A] = hex_seg;
    end
    seg_d = ~lit;
    if (phase_q && act_blink_q[idx_q]) begin
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      pend_mode_q  <= MODE_GRAPH;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      busy_q       <= 1'b0;
      act_mode_q   <= MODE_GRAPH;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      div_q <= step ? '0 : div_q + 1'b1;
      if (step) begin
        idx_q <= wrap ? '0 : idx_q + 1'b1;
      end

      if (wrap) begin
        fcnt_q <= fcnt_q + 1'b1;
        if (fcnt_q == '1) begin
          phase_q <= ~phase_q;
        end
      end

      // A load on the wrap edge bypasses pending and supersedes it.
      if (load && wrap) begin
        act_mode_q  <= mode_e'(mode);
        act_data_q  <= disp_data;
        act_dp_q    <= dp;
        act_blink_q <= blink_en;
        busy_q      <= 1'b0;
      end else if (load) begin
        pend_mode_q  <= mode_e'(mode);
        pend_data_q  <= disp_data;
        pend_dp_q    <= dp;
        pend_blink_q <= blink_en;
        busy_q       <= 1'b1;
      end else if (wrap && busy_q) begin
        act_mode_q  <= pend_mode_q;
        act_data_q  <= pend_data_q;
        act_dp_q    <= pend_dp_q;
        act_blink_q <= pend_blink_q;
        busy_q      <= 1'b0;
      end

      frame_tick_q <= wrap;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign busy       = busy_q;
  assign frame_tick = frame_tick_q;

endmodule
